// File: rtl/lfsr_random_arbiter.sv
// lfsr_random_arbiter
//   Pseudo-random N-way arbiter for a shared multi-beat port. A 6-bit
//   Fibonacci LFSR (x^6 + x^5 + 1) supplies the rotating scan start point for
//   each arbitration. Per-requester loss counters force a grant to the
//   lowest-index requester that has lost MAX_WAIT or more rounds. A grant is
//   held until the last beat of the granted transaction is accepted.
//
// Ports
//   clock          : clock, all state updates on posedge
//   reset          : synchronous, active-high reset
//   io_req         : [N_REQ] per-requester request level
//   io_fire        : one beat of the granted transaction accepted
//   io_last        : qualifies io_fire as the final beat
//   io_grant       : [N_REQ] registered one-hot grant
//   io_grant_valid : a grant is held (BUSY)
//   io_grant_idx   : [IDX_W] binary index of the granted requester
//   io_forced      : current grant came from the starvation override

// Per-requester loss counter: clears on a win, saturates at 15 on a loss,
// holds when the requester was not asking.
module lfsr_loss_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       arb,
    input  logic       req,
    input  logic       win,
    output logic [3:0] count,
    output logic       starved
);
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 4'd0;
        end else if (arb) begin
            if (win)
                count <= 4'd0;
            else if (req && count != 4'd15)
                count <= count + 4'd1;
        end
    end

    assign starved = (count >= 4'(MAX_WAIT));
endmodule

module lfsr_random_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_WAIT = 4,
    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] io_req,
    input  logic             io_fire,
    input  logic             io_last,
    output logic [N_REQ-1:0] io_grant,
    output logic             io_grant_valid,
    output logic [IDX_W-1:0] io_grant_idx,
    output logic             io_forced
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_next;
    logic [5:0]       lfsr, lfsr_next;
    logic [N_REQ-1:0] grant, grant_next;
    logic [IDX_W-1:0] grant_idx, grant_idx_next;
    logic             forced, forced_next;

    logic             arb;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             win_forced;
    logic             found;
    logic [N_REQ-1:0] win_onehot;
    logic [N_REQ-1:0] starved;

    // Start index comes from the pre-step LFSR value.
    assign start = lfsr[IDX_W-1:0];

    // Starved requesters beat the random scan; among them the lowest index
    // wins. Otherwise scan from start upward, wrapping naturally because
    // N_REQ is a power of two.
    always_comb begin
        winner     = '0;
        win_forced = 1'b0;
        found      = 1'b0;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && io_req[i] && starved[i]) begin
                winner     = IDX_W'(i);
                win_forced = 1'b1;
                found      = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            cand = start + IDX_W'(i);
            if (!found && io_req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign win_onehot = N_REQ'(1) << winner;

    always_comb begin
        state_next     = state;
        lfsr_next      = lfsr;
        grant_next     = grant;
        grant_idx_next = grant_idx;
        forced_next    = forced;
        arb            = 1'b0;
        case (state)
            IDLE: begin
                if (|io_req) begin
                    arb            = 1'b1;
                    state_next     = BUSY;
                    grant_next     = win_onehot;
                    grant_idx_next = winner;
                    forced_next    = win_forced;
                    lfsr_next      = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
                end
            end
            BUSY: begin
                // Request changes are ignored; only the last beat releases.
                if (io_fire && io_last) begin
                    state_next  = IDLE;
                    grant_next  = '0;
                    forced_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= 6'h01;
            grant     <= '0;
            grant_idx <= '0;
            forced    <= 1'b0;
        end else begin
            state     <= state_next;
            lfsr      <= lfsr_next;
            grant     <= grant_next;
            grant_idx <= grant_idx_next;
            forced    <= forced_next;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        lfsr_loss_counter #(.MAX_WAIT(MAX_WAIT)) u_cnt (
            .clock   (clock),
            .reset   (reset),
            .arb     (arb),
            .req     (io_req[g]),
            .win     (win_onehot[g]),
            .count   (),
            .starved (starved[g])
        );
    end

    assign io_grant       = grant;
    assign io_grant_valid = (state == BUSY);
    assign io_grant_idx   = grant_idx;
    assign io_forced      = forced;
endmodule

// File: tb/tb_lfsr_random_arbiter.sv
// Self-checking bench for lfsr_random_arbiter (N_REQ=4, MAX_WAIT=4).
// A behavioural model (integer LFSR arithmetic, loss-count array, loop-based
// winner search) is stepped at every clock edge and compared with the DUT;
// directed steps add fixed expected values from the arbitration rules.
module tb_lfsr_random_arbiter;
    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] io_req;
    logic       io_fire;
    logic       io_last;
    logic [3:0] io_grant;
    logic       io_grant_valid;
    logic [1:0] io_grant_idx;
    logic       io_forced;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_lfsr;
    int m_cnt[4];
    int m_busy;
    int m_idx;
    int m_forced;

    int exp_idx[5] = '{1, 2, 0, 0, 3};
    int exp_frc[5] = '{0, 0, 0, 0, 1};

    lfsr_random_arbiter #(.N_REQ(4), .MAX_WAIT(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_req         (io_req),
        .io_fire        (io_fire),
        .io_last        (io_last),
        .io_grant       (io_grant),
        .io_grant_valid (io_grant_valid),
        .io_grant_idx   (io_grant_idx),
        .io_forced      (io_forced)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_lfsr   = 1;
        m_busy   = 0;
        m_idx    = 0;
        m_forced = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endfunction

    // One clock edge of the arbitration rules, from the current inputs.
    function automatic void model_edge();
        int w;
        int st;
        if (reset) begin
            model_reset();
        end else if (m_busy == 0) begin
            if (io_req != 4'd0) begin
                w = -1;
                m_forced = 0;
                for (int i = 0; i < 4; i++)
                    if (w < 0 && io_req[i] && m_cnt[i] >= 4) begin
                        w = i;
                        m_forced = 1;
                    end
                st = m_lfsr % 4;
                for (int k = 0; k < 4; k++)
                    if (w < 0 && io_req[(st + k) % 4]) w = (st + k) % 4;
                for (int i = 0; i < 4; i++) begin
                    if (i == w) m_cnt[i] = 0;
                    else if (io_req[i] && m_cnt[i] < 15) m_cnt[i]++;
                end
                m_idx  = w;
                m_busy = 1;
                m_lfsr = ((m_lfsr * 2) % 64) + (((m_lfsr / 32) + (m_lfsr / 16)) % 2);
            end
        end else if (io_fire && io_last) begin
            m_busy   = 0;
            m_forced = 0;
        end
    endfunction

    task automatic check_model();
        chk("valid", 32'(io_grant_valid), 32'(m_busy));
        chk("grant", 32'(io_grant), m_busy != 0 ? (32'd1 << m_idx) : 32'd0);
        chk("forced", 32'(io_forced), m_busy != 0 ? 32'(m_forced) : 32'd0);
        if (m_busy != 0) chk("idx", 32'(io_grant_idx), 32'(m_idx));
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        reset   = 1'b1;
        io_req  = 4'b1111;
        io_fire = 1'b1;
        io_last = 1'b1;

        // Reset held two cycles with everything asserted
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rst_out", {io_grant, io_grant_valid, io_grant_idx, io_forced}, 32'd0);
        end
        reset = 1'b0;

        // Single-beat rotation with all requesting: fire/last held high
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("rot_valid", 32'(io_grant_valid), 32'd1);
            chk("rot_idx", 32'(io_grant_idx), 32'(exp_idx[k]));
            chk("rot_forced", 32'(io_forced), 32'(exp_frc[k]));
            cyc();
            chk("rot_bubble", 32'(io_grant_valid), 32'd0);
        end

        // Multi-beat hold while requests churn
        do_reset();
        io_fire = 1'b0;
        io_last = 1'b0;
        cyc();
        chk("mb_grant", 32'(io_grant), 32'h2);
        for (int b = 1; b <= 3; b++) begin
            io_req  = 4'($urandom_range(0, 15)) & 4'b1101;
            io_fire = 1'b1;
            io_last = (b == 3);
            cyc();
            chk("mb_hold", 32'(io_grant), b == 3 ? 32'h0 : 32'h2);
        end
        io_fire = 1'b0;
        io_last = 1'b0;

        // Sparse request: only requester 3
        do_reset();
        io_req = 4'b1000;
        cyc();
        chk("sparse_idx", 32'(io_grant_idx), 32'd3);
        io_fire = 1'b1;
        io_last = 1'b1;
        cyc();
        io_fire = 1'b0;
        io_last = 1'b0;
        io_req  = 4'b1111;
        cyc();
        chk("sparse_next", 32'(io_grant_idx), 32'd2);

        // Idle stability: no requests, random fire/last
        io_fire = 1'b1;
        io_last = 1'b1;
        cyc();
        do_reset();
        io_req = 4'b0000;
        for (int i = 0; i < 100; i++) begin
            io_fire = 1'($urandom_range(0, 1));
            io_last = 1'($urandom_range(0, 1));
            cyc();
        end
        io_fire = 1'b0;
        io_last = 1'b0;
        io_req  = 4'b1111;
        cyc();
        chk("idle_idx", 32'(io_grant_idx), 32'd1);

        // Reset mid-transaction after loss counters have built up
        do_reset();
        io_fire = 1'b1;
        io_last = 1'b1;
        for (int k = 0; k < 8; k++) cyc();
        io_fire = 1'b0;
        io_last = 1'b0;
        cyc();
        chk("mr_forced_pre", 32'(io_forced), 32'd1);
        io_fire = 1'b1;
        cyc();
        reset = 1'b1;
        cyc();
        chk("mr_cleared", {io_grant, io_grant_valid, io_forced}, 32'd0);
        reset   = 1'b0;
        io_fire = 1'b0;
        cyc();
        chk("mr_idx", 32'(io_grant_idx), 32'd1);
        chk("mr_forced", 32'(io_forced), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            reset   = ($urandom_range(0, 63) == 0);
            io_req  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            io_fire = 1'($urandom_range(0, 1));
            io_last = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
